// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the mm:ss stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } sw_state_t;

  typedef logic [5:0] sw_count_t;

  localparam sw_count_t SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic      start_stop_p;
  logic      clear_p;
  logic      lap_p;
  sw_count_t sec_out;
  sw_count_t min_out;
  logic      running;
  logic      tick_1s;
  logic      ovf;
  logic      lap_held;

  modport master (
    output start_stop_p, clear_p, lap_p,
    input  sec_out, min_out, running, tick_1s, ovf, lap_held
  );

  modport slave (
    input  start_stop_p, clear_p, lap_p,
    output sec_out, min_out, running, tick_1s, ovf, lap_held
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the board clock down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tick = en && !clr && (count_reg == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: FSM, mm:ss counter and optional lap hold.
// Lap hold is compiled in when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 59
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave sw
);

  localparam sw_count_t MIN_LAST = sw_count_t'(MAX_MIN);

  sw_state_t state_reg;
  sw_state_t state_next;
  logic      running_reg;

  logic      presc_en;
  logic      presc_clr;
  logic      tick_fire;

  sw_count_t sec_reg;
  sw_count_t sec_next;
  sw_count_t min_reg;
  sw_count_t min_next;
  logic      wrap_next;
  logic      tick_reg;
  logic      ovf_reg;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick_fire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      running_reg <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sw.start_stop_p) state_next = RUN;
      RUN:     if (sw.start_stop_p) state_next = PAUSED;
      PAUSED:  if (sw.start_stop_p) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (sw.clear_p) begin
      state_next = IDLE;
    end
  end

  // Prescaler runs only in RUN, holds in PAUSED and is zeroed in IDLE or on clear.
  always_comb begin
    presc_en  = (state_reg == RUN);
    presc_clr = sw.clear_p || (state_reg == IDLE);
  end

  always_comb begin
    sec_next  = sec_reg;
    min_next  = min_reg;
    wrap_next = 1'b0;
    if (sw.clear_p) begin
      sec_next = '0;
      min_next = '0;
    end else if (tick_fire) begin
      if (sec_reg < SEC_MAX) begin
        sec_next = sec_reg + 6'd1;
      end else begin
        sec_next = '0;
        if (min_reg < MIN_LAST) begin
          min_next = min_reg + 6'd1;
        end else begin
          min_next  = '0;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_reg  <= '0;
      min_reg  <= '0;
      tick_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      sec_reg  <= sec_next;
      min_reg  <= min_next;
      tick_reg <= tick_fire;
      ovf_reg  <= wrap_next;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic      lap_held_reg;
  logic      lap_held_next;
  logic      lap_toggle;
  sw_count_t lap_sec_reg;
  sw_count_t lap_min_reg;

  always_comb begin
    lap_toggle    = sw.lap_p && (state_reg != IDLE);
    lap_held_next = lap_held_reg;
    if (sw.clear_p) begin
      lap_held_next = 1'b0;
    end else if (lap_toggle) begin
      lap_held_next = !lap_held_reg;
    end
  end

  // The frozen value is the count visible just before the toggle edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_held_reg <= 1'b0;
      lap_sec_reg  <= '0;
      lap_min_reg  <= '0;
    end else begin
      lap_held_reg <= lap_held_next;
      if (lap_toggle && !lap_held_reg && !sw.clear_p) begin
        lap_sec_reg <= sec_reg;
        lap_min_reg <= min_reg;
      end
    end
  end

  assign sw.sec_out  = lap_held_reg ? lap_sec_reg : sec_reg;
  assign sw.min_out  = lap_held_reg ? lap_min_reg : min_reg;
  assign sw.lap_held = lap_held_reg;
`else
  assign sw.sec_out  = sec_reg;
  assign sw.min_out  = min_reg;
  assign sw.lap_held = 1'b0;
`endif

  assign sw.running = running_reg;
  assign sw.tick_1s = tick_reg;
  assign sw.ovf     = ovf_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, MAX_MIN=1.
module tb_stopwatch_ctrl;

  typedef struct {
    string name;
    bit    ss;
    bit    clr;
    bit    lap;
    int    ncyc;
    int    sec;
    int    min;
    bit    run;
    bit    tick;
    bit    ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  vec_t vecs[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV(4),
    .MAX_MIN (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic check_all(input string name, input int sec, input int min,
                           input bit run, input bit tick, input bit ovf);
    check({name, ".sec"}, sw_if.sec_out, sec);
    check({name, ".min"}, sw_if.min_out, min);
    check({name, ".running"}, sw_if.running, run);
    check({name, ".tick"}, sw_if.tick_1s, tick);
    check({name, ".ovf"}, sw_if.ovf, ovf);
  endtask

  task automatic pulse(input bit ss, input bit clr, input bit lap);
    sw_if.start_stop_p = ss;
    sw_if.clear_p      = clr;
    sw_if.lap_p        = lap;
    step(1);
    sw_if.start_stop_p = 1'b0;
    sw_if.clear_p      = 1'b0;
    sw_if.lap_p        = 1'b0;
  endtask

  task automatic add(input string name, input bit ss, input bit clr, input bit lap, input int ncyc,
                     input int sec, input int min, input bit run, input bit tick, input bit ovf);
    vec_t v;
    v.name = name; v.ss = ss; v.clr = clr; v.lap = lap; v.ncyc = ncyc;
    v.sec = sec; v.min = min; v.run = run; v.tick = tick; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    passed = 0;

    //   name           ss clr lap n   sec min run tick ovf
    add("start",        1, 0, 0, 1,  0,  0,  1,  0,  0);
    add("pre_tick",     0, 0, 0, 3,  0,  0,  1,  0,  0);
    add("tick1",        0, 0, 0, 1,  1,  0,  1,  1,  0);
    add("tick1_drop",   0, 0, 0, 1,  1,  0,  1,  0,  0);
    add("tick2",        0, 0, 0, 3,  2,  0,  1,  1,  0);
    add("tick3",        0, 0, 0, 4,  3,  0,  1,  1,  0);
    add("part_sec",     0, 0, 0, 1,  3,  0,  1,  0,  0);
    add("pause",        1, 0, 0, 1,  3,  0,  0,  0,  0);
    add("paused",       0, 0, 0, 10, 3,  0,  0,  0,  0);
    add("resume",       1, 0, 0, 1,  3,  0,  1,  0,  0);
    add("resume_wait",  0, 0, 0, 1,  3,  0,  1,  0,  0);
    add("resume_tick",  0, 0, 0, 1,  4,  0,  1,  1,  0);
    add("clear_and_ss", 1, 1, 0, 1,  0,  0,  0,  0,  0);
    add("idle_hold",    0, 0, 0, 6,  0,  0,  0,  0,  0);

    // Reset held for two cycles with every button pulse active.
    rst_n = 1'b0;
    sw_if.start_stop_p = 1'b1;
    sw_if.clear_p      = 1'b1;
    sw_if.lap_p        = 1'b1;
    step(2);
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.lap_held", sw_if.lap_held, 0);
    rst_n = 1'b1;
    sw_if.start_stop_p = 1'b0;
    sw_if.clear_p      = 1'b0;
    sw_if.lap_p        = 1'b0;
    step(1);
    check_all("post_reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      pulse(vecs[i].ss, vecs[i].clr, vecs[i].lap);
      for (int c = 1; c < vecs[i].ncyc; c++) begin
        check({vecs[i].name, ".mid_tick"}, sw_if.tick_1s, 0);
        check({vecs[i].name, ".mid_ovf"}, sw_if.ovf, 0);
        step(1);
      end
      check_all(vecs[i].name, vecs[i].sec, vecs[i].min, vecs[i].run, vecs[i].tick, vecs[i].ovf);
    end

    // Reset on the edge where a tick would fire: nothing is emitted.
    pulse(1, 0, 0);
    step(3);
    rst_n = 1'b0;
    step(1);
    check_all("reset_mid", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(4);
    check_all("after_reset_mid", 0, 0, 0, 0, 0);

    // Full 120 s run with wrap, then a start_stop_p coinciding with a tick.
    pulse(1, 0, 0);
    for (int k = 1; k <= 489; k++) begin
      int  s;
      bit  tk;
      bit  run;
      s   = (k > 488) ? 122 : k / 4;
      tk  = (k <= 488) && (k % 4 == 0);
      run = (k < 488);
      if (k == 488) begin
        pulse(1, 0, 0);
      end else begin
        step(1);
      end
      check_all($sformatf("run120.k%0d", k), s % 60, (s / 60) % 2, run, tk,
                tk && (s % 120 == 0));
    end
    pulse(0, 1, 0);
    check_all("cleared", 0, 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_HOLD_EN
    pulse(0, 0, 1);
    check("lap_idle.lap_held", sw_if.lap_held, 0);
    pulse(1, 0, 0);
    step(20);
    check("lap.sec_before", sw_if.sec_out, 5);
    pulse(0, 0, 1);
    check("lap.held", sw_if.lap_held, 1);
    check("lap.sec_frozen", sw_if.sec_out, 5);
    step(31);
    check("lap.sec_still", sw_if.sec_out, 5);
    check("lap.tick_live", sw_if.tick_1s, 1);
    pulse(0, 0, 1);
    check("lap.released", sw_if.lap_held, 0);
    check("lap.sec_live", sw_if.sec_out, 13);
    step(3);
    check("lap.sec_next", sw_if.sec_out, 14);
`else
    pulse(1, 0, 0);
    step(20);
    check("lap.sec_before", sw_if.sec_out, 5);
    pulse(0, 0, 1);
    check("lap.ignored", sw_if.lap_held, 0);
    step(31);
    check("lap.sec_live", sw_if.sec_out, 13);
    check("lap.still_ignored", sw_if.lap_held, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
